// File: rtl/pipe_stall_sched.sv
// Stall/flush scheduler for the 5-stage RISC-V pipeline: arbitrates memory wait,
// EX redirect and load-use stalls, and keeps saturating performance counters.
module pipe_stall_sched #(
  parameter int unsigned LU_STALL    = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             pc_sel_target,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_events
);

  typedef enum logic [1:0] {RUN, LU_HOLD, MEM_WAIT} state_e;

  localparam logic [2:0]  LU_RELOAD   = 3'(LU_STALL - 1);
  localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_q, redir_d;

  logic lu_hit;
  logic freeze;
  logic do_redirect;
  logic do_lu_stall;

  assign lu_hit = idex_mem_read && (idex_rd != 5'd0) &&
                  ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                   (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

  // Once timed out the pipe stays frozen even if an ack shows up late.
  always_comb begin
    freeze      = (state_q == MEM_WAIT) ? (!dmem_ack || timeout_q)
                                        : (dmem_req && !dmem_ack);
    do_redirect = !freeze && ex_redirect;
    do_lu_stall = !freeze && !ex_redirect && ((state_q == LU_HOLD) || lu_hit);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_target = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_flush    = 1'b0;
    exmem_write   = 1'b1;
    memwb_bubble  = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (do_redirect) begin
      pc_sel_target = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
    end else if (do_lu_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (freeze) begin
      // An interrupted LU_HOLD keeps its remaining count through the wait.
      state_d = MEM_WAIT;
      if ((state_q == MEM_WAIT) && (wait_cnt_q != TIMEOUT_CNT)) wait_cnt_d = wait_cnt_q + 16'd1;
      if (wait_cnt_d == TIMEOUT_CNT) timeout_d = 1'b1;
    end else begin
      wait_cnt_d = 16'd0;
      if (do_redirect) begin
        state_d  = RUN;
        lu_cnt_d = 3'd0;
      end else if (state_q == LU_HOLD) begin
        lu_cnt_d = (lu_cnt_q == 3'd0) ? 3'd0 : lu_cnt_q - 3'd1;
        state_d  = (lu_cnt_q <= 3'd1) ? RUN : LU_HOLD;
      end else if (lu_hit) begin
        lu_cnt_d = LU_RELOAD;
        state_d  = (LU_RELOAD != 3'd0) ? LU_HOLD : RUN;
      end else begin
        state_d = (lu_cnt_q != 3'd0) ? LU_HOLD : RUN;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    redir_d = redir_q;
    if (!pc_write && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (pc_sel_target && (redir_q != '1)) redir_d = redir_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      lu_cnt_q   <= 3'd0;
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      redir_q    <= '0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      redir_q    <= redir_d;
    end
  end

  assign mem_timeout     = timeout_q;
  assign stall_cycles    = stall_q;
  assign redirect_events = redir_q;

endmodule
